// File: rtl/axi_lite_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master_pkg
// Shared definitions for the AXI4-Lite command master: FSM state encoding,
// AXI response codes and default timeout sizing.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_lite_cmd_master_pkg;

    // Master FSM states. The four wait states are where the timeout counter runs.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        RSP   = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int DEFAULT_CNT_W   = 11;

    // Clears the two byte-offset bits so every bus access is word aligned.
    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

    // True in every state that waits on an AXI handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == RD_A) || (s == RD_D) || (s == WR_AW) || (s == WR_B);
    endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// ---------------------------------------------------------------------------
// axi_lite_timeout_ctr
// Per-phase watchdog for the AXI command master. Counts cycles while enabled,
// restarts from zero on clear, and flags expiry on the last allowed cycle.
// Ports:
//   clk_i     clock, all logic on posedge
//   rst_i     synchronous active-high reset
//   clear_i   restart count at zero (has priority over enable)
//   enable_i  count this cycle (sitting in a wait state)
//   expire_o  this is cycle TIMEOUT_CYC of the phase; never set when TIMEOUT_CYC == 0
// ---------------------------------------------------------------------------
module axi_lite_timeout_ctr
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a clear always wins so a fresh phase starts at zero even if
    // the previous phase ended on the same cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is taken from the registered count, so it never depends on the
    // clear it indirectly causes.
    assign expire_o = (TIMEOUT_CYC != 0) && enable_i && (count_q == LAST_CNT);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
// Turns a single-outstanding memory command port into AXI4-Lite master
// transactions, with word alignment, response-error reporting and a per-phase
// timeout. Every output is registered.
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   req_valid_i / req_ready_o    command handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_wstrb_i     command fields (addr bits [1:0] ignored)
//   rsp_valid_o                  one-cycle completion pulse
//   rsp_rdata_o                  read data, 0 for writes/errors, held between pulses
//   rsp_err_o, rsp_timeout_o     error flag and timeout cause
//   m_axi_*                      AXI4-Lite master read and write channels
// ---------------------------------------------------------------------------
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o
);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic        aw_done, w_done;
    logic        aw_open, w_open;
    logic        abort;
    logic        expire;

    // The watchdog restarts on every state change and only counts while the
    // FSM is parked waiting for the slave.
    axi_lite_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_d != state_q),
        .enable_i (is_wait_state(state_q)),
        .expire_o (expire)
    );

    // Next-state and next-output logic. Everything defaults to holding its
    // value except rsp_valid, which is a single-cycle pulse. A completed
    // handshake is checked before expiry, so a late handshake still succeeds.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        // AW and W complete independently; the write phase ends once neither
        // is still outstanding after this cycle.
        aw_done = awvalid_q & m_axi_awready_i;
        w_done  = wvalid_q & m_axi_wready_i;
        aw_open = awvalid_q & ~aw_done;
        w_open  = wvalid_q & ~w_done;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i && req_ready_q) begin
                    req_ready_d = 1'b0;
                    addr_d      = req_addr_i & ADDR_WORD_MASK;
                    wdata_d     = req_wdata_i;
                    wstrb_d     = req_wstrb_i;
                    if (req_we_i) begin
                        state_d   = WR_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_A: begin
                if (arvalid_q && m_axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            RD_D: begin
                if (rready_q && m_axi_rvalid_i) begin
                    rready_d      = 1'b0;
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_err_d     = (m_axi_rresp_i != RESP_OKAY);
                    rsp_rdata_d   = (m_axi_rresp_i != RESP_OKAY) ? 32'h0 : m_axi_rdata_i;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            WR_AW: begin
                if (aw_done) awvalid_d = 1'b0;
                if (w_done)  wvalid_d  = 1'b0;
                if (!aw_open && !w_open) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            WR_B: begin
                if (bready_q && m_axi_bvalid_i) begin
                    bready_d      = 1'b0;
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_err_d     = (m_axi_bresp_i != RESP_OKAY);
                    rsp_rdata_d   = 32'h0;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout: withdraw every AXI request and report the failure.
        if (abort) begin
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            state_d       = RSP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = 32'h0;
        end
    end

    // State and output registers. Reset clears every output, including
    // req_ready, which comes up the cycle after reset is released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_err_o       = rsp_err_q;
    assign rsp_timeout_o   = rsp_timeout_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_master
// Directed bench for axi_lite_cmd_master with a small BRAM-like AXI-Lite
// slave whose per-channel latencies and responses are set per test.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_master;
    import axi_lite_cmd_master_pkg::*;

    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;
    logic [3:0]  wstrb_o;
    logic        arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int totalChecks = 0;
    int badChecks   = 0;

    // Slave configuration and state.
    int          arLat, awLat, wLat;
    bit          arEnable, bEnable, forceR;
    logic [31:0] forceRdata;
    logic [1:0]  rrespVal, brespVal;
    int          arCnt, awCnt, wCnt;
    bit          rdPending, awGot, wGot, bPending;
    logic [31:0] rdAddr, wrAddr, wrData;
    logic [3:0]  wrStrb;
    logic [31:0] mem [0:15];

    // Monitors.
    int breadyRise = 0;
    int arHighCnt  = 0;
    int rspCount   = 0;
    bit breadyPrev = 1'b0;
    bit wFirstSeen = 1'b0;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .TIMEOUT_CYC (TO_CYC),
        .CNT_W       (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_wstrb_i     (req_wstrb),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_timeout_o   (rsp_timeout_o),
        .m_axi_araddr_o  (araddr_o),
        .m_axi_arvalid_o (arvalid_o),
        .m_axi_arready_i (arready),
        .m_axi_rdata_i   (rdata),
        .m_axi_rresp_i   (rresp),
        .m_axi_rvalid_i  (rvalid),
        .m_axi_rready_o  (rready_o),
        .m_axi_awaddr_o  (awaddr_o),
        .m_axi_awvalid_o (awvalid_o),
        .m_axi_awready_i (awready),
        .m_axi_wdata_o   (wdata_o),
        .m_axi_wstrb_o   (wstrb_o),
        .m_axi_wvalid_o  (wvalid_o),
        .m_axi_wready_i  (wready),
        .m_axi_bresp_i   (bresp),
        .m_axi_bvalid_i  (bvalid),
        .m_axi_bready_o  (bready_o)
    );

    // Slave model, updated on the falling edge. A ready/valid is only raised
    // while the matching master signal is high, so the handshake is certain
    // on the next rising edge and the signal is dropped on the falling edge after.
    always @(negedge clk) begin
        if (rst) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            rdata = '0; rresp = '0; bresp = '0;
            arCnt = 0; awCnt = 0; wCnt = 0;
            rdPending = 0; awGot = 0; wGot = 0; bPending = 0;
        end else begin
            if (arready) begin
                arready = 0; rdPending = 1;
            end else if (arvalid_o && arEnable) begin
                if (arCnt >= arLat) begin arready = 1; rdAddr = araddr_o; arCnt = 0; end
                else arCnt++;
            end
            if (rvalid) rvalid = 0;
            else if (rdPending && rready_o) begin
                rvalid = 1; rresp = rrespVal; rdPending = 0;
                rdata = forceR ? forceRdata : mem[rdAddr[5:2]];
            end
            if (awready) begin
                awready = 0; awGot = 1;
            end else if (awvalid_o) begin
                if (awCnt >= awLat) begin awready = 1; wrAddr = awaddr_o; awCnt = 0; end
                else awCnt++;
            end
            if (wready) begin
                wready = 0; wGot = 1;
            end else if (wvalid_o) begin
                if (wCnt >= wLat) begin wready = 1; wrData = wdata_o; wrStrb = wstrb_o; wCnt = 0; end
                else wCnt++;
            end
            if (awGot && wGot) begin
                for (int b = 0; b < 4; b++)
                    if (wrStrb[b]) mem[wrAddr[5:2]][8*b +: 8] = wrData[8*b +: 8];
                awGot = 0; wGot = 0; bPending = 1;
            end
            if (bvalid) bvalid = 0;
            else if (bPending && bready_o && bEnable) begin
                bvalid = 1; bresp = brespVal; bPending = 0;
            end
        end
    end

    // Event monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (rsp_valid_o) rspCount++;
        if (arvalid_o) arHighCnt++;
        if (bready_o && !breadyPrev) breadyRise++;
        breadyPrev = bready_o;
        if (awvalid_o && !wvalid_o) wFirstSeen = 1'b1;
    end

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one command and returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] strb);
        int n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 40) begin @(negedge clk); n++; end
        if (!req_ready_o) checkOutput("reqReadyWait", {31'b0, req_ready_o}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for the response pulse and checks its framing.
    task automatic waitResponse(output logic [31:0] rd, output logic err, output logic tmo,
                                output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin @(negedge clk); lat++; end
        checkOutput("rspSeen", {31'b0, rsp_valid_o}, 32'd1);
        checkOutput("readyLowInRsp", {31'b0, req_ready_o}, 32'd0);
        rd = rsp_rdata_o; err = rsp_err_o; tmo = rsp_timeout_o;
        @(negedge clk);
        checkOutput("rspPulseEnd", {31'b0, rsp_valid_o}, 32'd0);
        checkOutput("readyBack", {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err, tmo;
        int          lat, snap, snap2;

        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        arLat = 0; awLat = 0; wLat = 0; arEnable = 1; bEnable = 1; forceR = 0;
        forceRdata = '0; rrespVal = RESP_OKAY; brespVal = RESP_OKAY;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[4] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", {23'b0, req_ready_o, arvalid_o, rready_o, awvalid_o, wvalid_o,
                                     bready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
        checkOutput("resetRdata", rsp_rdata_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", {31'b0, req_ready_o}, 32'd1);

        // 1: aligned read of word 4.
        applyStimulus(1'b0, 32'h0000_0013, 32'h0, 4'h0);
        checkOutput("t1Arvalid", {31'b0, arvalid_o}, 32'd1);
        checkOutput("t1Araddr", araddr_o, 32'h0000_0010);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t1Rdata", rd, 32'hDEAD_BEEF);
        checkOutput("t1Err", {31'b0, err}, 32'd0);
        checkOutput("t1Latency", lat, 32'd3);

        // 2: partial write then read back.
        applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
        checkOutput("t2Awaddr", awaddr_o, 32'h0000_0020);
        checkOutput("t2Wstrb", {28'b0, wstrb_o}, 32'h3);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t2WrErr", {30'b0, err, tmo}, 32'd0);
        checkOutput("t2WrRdata", rd, 32'd0);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t2Readback", rd, 32'h0000_5678);
        checkOutput("t2SameDrop", {31'b0, wFirstSeen}, 32'd0);

        // 3: W accepted three cycles before AW.
        awLat = 3; wLat = 0;
        snap = breadyRise;
        applyStimulus(1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'hF);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t3Err", {31'b0, err}, 32'd0);
        checkOutput("t3WFirst", {31'b0, wFirstSeen}, 32'd1);
        checkOutput("t3BreadyPhases", breadyRise - snap, 32'd1);
        awLat = 0;
        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t3Readback", rd, 32'hAABB_CCDD);

        // 4: read error response masks the data.
        forceR = 1; forceRdata = 32'hFFFF_FFFF; rrespVal = RESP_SLVERR;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t4ErrTmo", {30'b0, err, tmo}, 32'd2);
        checkOutput("t4Rdata", rd, 32'd0);
        forceR = 0; rrespVal = RESP_OKAY;

        // 4b: write error response.
        brespVal = RESP_SLVERR;
        applyStimulus(1'b1, 32'h0000_0028, 32'h0000_0001, 4'hF);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t4bErrTmo", {30'b0, err, tmo}, 32'd2);
        brespVal = RESP_OKAY;

        // 5: AR never accepted, phase times out after TO_CYC cycles.
        arEnable = 0;
        snap = arHighCnt;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t5ArHighCycles", arHighCnt - snap, 32'd8);
        checkOutput("t5ErrTmo", {30'b0, err, tmo}, 32'd3);
        checkOutput("t5Rdata", rd, 32'd0);
        checkOutput("t5Latency", lat, 32'd9);
        checkOutput("t5ArvalidLow", {31'b0, arvalid_o}, 32'd0);
        arEnable = 1;

        // 6: reset while waiting for B.
        bEnable = 0;
        applyStimulus(1'b1, 32'h0000_002C, 32'h5555_AAAA, 4'hF);
        snap = 0;
        while (!bready_o && snap < 20) begin @(negedge clk); snap++; end
        checkOutput("t6ReachWrB", {31'b0, bready_o}, 32'd1);
        snap2 = rspCount;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6ValidsCleared", {25'b0, req_ready_o, arvalid_o, rready_o, awvalid_o,
                                        wvalid_o, bready_o, rsp_valid_o}, 32'd0);
        rst = 1'b0; bEnable = 1;
        repeat (3) @(negedge clk);
        checkOutput("t6NoRsp", rspCount - snap2, 32'd0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        waitResponse(rd, err, tmo, lat);
        checkOutput("t6ReadAfterReset", rd, 32'hDEAD_BEEF);
        checkOutput("t6Err", {31'b0, err}, 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
